decode_stage: RTL and testbench

// - Instruction-decode stage: producer of the ALU operand bus (ID_opcode, ID_fn_3, ID_fn_7, ID_rs1_val, ID_mux_val).
// - Accepts fetched instructions via valid/ready, reads an internal 32x32 register file, builds immediates.
// - Registers all ID_* outputs in a one-entry pipeline register; takes writeback from the WB stage.

---
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, immediate generation and a one-entry ID_* output register.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into the operand read.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           IF_instr,
    input  logic                  IF_valid,
    output logic                  ID_ready,
    input  logic                  ALU_ready,
    input  logic                  flush,
    input  logic                  WB_we,
    input  logic [REG_ADDR_W-1:0] WB_rd,
    input  logic [XLEN-1:0]       WB_val,
    output logic                  ID_valid,
    output logic [6:0]            ID_opcode,
    output logic [2:0]            ID_fn_3,
    output logic [6:0]            ID_fn_7,
    output logic [REG_ADDR_W-1:0] ID_rd,
    output logic [XLEN-1:0]       ID_rs1_val,
    output logic [XLEN-1:0]       ID_rs2_val,
    output logic [XLEN-1:0]       ID_mux_val,
    output logic                  ID_illegal
);

    localparam int NREG = 1 << REG_ADDR_W;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [XLEN-1:0]       rf_q [NREG];
    logic                  valid_q, valid_d;
    logic [6:0]            opcode_q, opcode_d;
    logic [2:0]            fn3_q, fn3_d;
    logic [6:0]            fn7_q, fn7_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       rs1_q, rs1_d;
    logic [XLEN-1:0]       rs2_q, rs2_d;
    logic [XLEN-1:0]       mux_q, mux_d;
    logic                  illegal_q, illegal_d;

    logic                  capture;
    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
    logic [XLEN-1:0]       rs1_rd, rs2_rd;
    logic [XLEN-1:0]       imm_i, imm_s;

    assign ID_ready = !valid_q || ALU_ready;
    assign capture  = IF_valid && ID_ready && !flush;
    assign rs1_idx  = IF_instr[15 +: REG_ADDR_W];
    assign rs2_idx  = IF_instr[20 +: REG_ADDR_W];
    assign imm_i    = {{(XLEN-12){IF_instr[31]}}, IF_instr[31:20]};
    assign imm_s    = {{(XLEN-12){IF_instr[31]}}, IF_instr[31:25], IF_instr[11:7]};

    always_comb begin
        rs1_rd = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
        rs2_rd = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        // Forward the writeback landing on this same edge; x0 is never forwarded.
        if (WB_we && WB_rd != '0 && WB_rd == rs1_idx) rs1_rd = WB_val;
        if (WB_we && WB_rd != '0 && WB_rd == rs2_idx) rs2_rd = WB_val;
`endif
    end

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        fn3_d     = fn3_q;
        fn7_d     = fn7_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        mux_d     = mux_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            opcode_d  = IF_instr[6:0];
            fn3_d     = IF_instr[14:12];
            fn7_d     = IF_instr[31:25];
            rd_d      = IF_instr[7 +: REG_ADDR_W];
            rs1_d     = rs1_rd;
            rs2_d     = rs2_rd;
            illegal_d = 1'b0;
            case (IF_instr[6:0])
                OP_R:          mux_d = rs2_rd;
                OP_I, OP_LOAD: mux_d = imm_i;
                OP_STORE:      mux_d = imm_s;
                default: begin
                    mux_d     = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end else if (ALU_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            fn3_q     <= '0;
            fn7_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            mux_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            fn3_q     <= fn3_d;
            fn7_q     <= fn7_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            mux_q     <= mux_d;
            illegal_q <= illegal_d;
        end
    end

    // Writeback is independent of the pipeline handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (WB_we && WB_rd != '0) begin
            rf_q[WB_rd] <= WB_val;
        end
    end

    assign ID_valid   = valid_q;
    assign ID_opcode  = opcode_q;
    assign ID_fn_3    = fn3_q;
    assign ID_fn_7    = fn7_q;
    assign ID_rd      = rd_q;
    assign ID_rs1_val = rs1_q;
    assign ID_rs2_val = rs2_q;
    assign ID_mux_val = mux_q;
    assign ID_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles are queued at capture and compared after the edge.
module tb_decode_stage;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] mux;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_instr;
    logic        IF_valid, ID_ready, ALU_ready, flush, WB_we;
    logic [4:0]  WB_rd;
    logic [31:0] WB_val;
    logic        ID_valid;
    logic [6:0]  ID_opcode;
    logic [2:0]  ID_fn_3;
    logic [6:0]  ID_fn_7;
    logic [4:0]  ID_rd;
    logic [31:0] ID_rs1_val, ID_rs2_val, ID_mux_val;
    logic        ID_illegal;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .IF_instr(IF_instr), .IF_valid(IF_valid),
        .ID_ready(ID_ready), .ALU_ready(ALU_ready), .flush(flush),
        .WB_we(WB_we), .WB_rd(WB_rd), .WB_val(WB_val),
        .ID_valid(ID_valid), .ID_opcode(ID_opcode), .ID_fn_3(ID_fn_3),
        .ID_fn_7(ID_fn_7), .ID_rd(ID_rd), .ID_rs1_val(ID_rs1_val),
        .ID_rs2_val(ID_rs2_val), .ID_mux_val(ID_mux_val), .ID_illegal(ID_illegal)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bundle_t     sb_q[$];
    bundle_t     last;
    logic        m_valid;
    logic [31:0] m_rf [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wv);
        logic [31:0] v;
        v = (idx == 5'd0) ? 32'd0 : m_rf[idx];
`ifdef DECODE_WB_BYPASS_EN
        if (we && wrd != 5'd0 && wrd == idx) v = wv;
`endif
        return v;
    endfunction

    function automatic bundle_t model(input logic [31:0] ins, input logic we,
                                      input logic [4:0] wrd, input logic [31:0] wv);
        bundle_t b;
        b.op  = ins[6:0];
        b.f3  = ins[14:12];
        b.f7  = ins[31:25];
        b.rd  = ins[11:7];
        b.rs1 = rd_reg(ins[19:15], we, wrd, wv);
        b.rs2 = rd_reg(ins[24:20], we, wrd, wv);
        b.ill = 1'b0;
        case (ins[6:0])
            7'h33:        b.mux = b.rs2;
            7'h13, 7'h03: b.mux = 32'($signed(ins) >>> 20);
            7'h23:        b.mux = 32'($signed({ins[31:25], ins[11:7], 20'd0}) >>> 20);
            default: begin
                b.mux = 32'd0;
                b.ill = 1'b1;
            end
        endcase
        return b;
    endfunction

    task automatic check_outputs(input string ctx);
        chk({ctx, ".valid"},   32'(ID_valid),   32'(m_valid));
        chk({ctx, ".opcode"},  32'(ID_opcode),  32'(last.op));
        chk({ctx, ".fn3"},     32'(ID_fn_3),    32'(last.f3));
        chk({ctx, ".fn7"},     32'(ID_fn_7),    32'(last.f7));
        chk({ctx, ".rd"},      32'(ID_rd),      32'(last.rd));
        chk({ctx, ".rs1"},     ID_rs1_val,      last.rs1);
        chk({ctx, ".rs2"},     ID_rs2_val,      last.rs2);
        chk({ctx, ".mux"},     ID_mux_val,      last.mux);
        chk({ctx, ".illegal"}, 32'(ID_illegal), 32'(last.ill));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        last    = '0;
        sb_q.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    // One clock: drive at posedge+1, check ready, queue any capture, compare after the edge.
    task automatic cycle(input string ctx, input logic iv, input logic [31:0] ins,
                         input logic ar, input logic fl, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wv);
        logic cap;
        IF_valid = iv; IF_instr = ins; ALU_ready = ar; flush = fl;
        WB_we = we; WB_rd = wrd; WB_val = wv;
        #1;
        chk({ctx, ".ready"}, 32'(ID_ready), 32'(!m_valid || ar));
        cap = iv && (!m_valid || ar) && !fl;
        if (cap) sb_q.push_back(model(ins, we, wrd, wv));
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) m_rf[wrd] = wv;
        if (fl)       m_valid = 1'b0;
        else if (cap) m_valid = 1'b1;
        else if (ar)  m_valid = 1'b0;
        if (cap) begin
            if (sb_q.size() == 0) chk({ctx, ".sb_empty"}, 32'd0, 32'd1);
            else last = sb_q.pop_front();
        end
        check_outputs(ctx);
    endtask

    task automatic idle(input string ctx, input logic ar);
        cycle(ctx, 1'b0, 32'd0, ar, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wb(input string ctx, input logic [4:0] wrd, input logic [31:0] wv);
        cycle(ctx, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, wrd, wv);
    endtask

    logic [6:0] ops [5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h7F};

    initial begin
        rst_n = 1'b0;
        IF_valid = 1'b0; IF_instr = '0; ALU_ready = 1'b0; flush = 1'b0;
        WB_we = 1'b0; WB_rd = '0; WB_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        cycle("addi", 1'b1, 32'hFFB00093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi.mux_lit", ID_mux_val, 32'hFFFFFFFB);
        idle("drain0", 1'b1);

        wb("wb_x2", 5'd2, 32'h10);
        wb("wb_x3", 5'd3, 32'h20);
        cycle("sub", 1'b1, 32'h40310233, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sub.rs1_lit", ID_rs1_val, 32'h10);
        chk("sub.mux_lit", ID_mux_val, 32'h20);
        cycle("sw", 1'b1, 32'hFE312E23, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sw.mux_lit", ID_mux_val, 32'hFFFFFFFC);
        chk("sw.rs2_lit", ID_rs2_val, 32'h20);

        // Stall three cycles with a pending instruction, then release.
        for (int i = 0; i < 3; i++)
            cycle("stall", 1'b1, 32'h00812483, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("lw", 1'b1, 32'h00812483, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle("srai", 1'b1, 32'h4030D513, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("srai.mux_lit", ID_mux_val, 32'h00000403);

        cycle("flush", 1'b1, 32'h00000433, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("illegal", 1'b1, 32'h1234507F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("illegal.lit", 32'(ID_illegal), 32'd1);
        cycle("flush_stall", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);

        cycle("bypass", 1'b1, 32'h00028333, 1'b1, 1'b0, 1'b1, 5'd5, 32'hABCD);
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass.lit", ID_rs1_val, 32'hABCD);
`else
        chk("bypass.lit", ID_rs1_val, 32'd0);
`endif
        cycle("after_wb", 1'b1, 32'h00028333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("after_wb.lit", ID_rs1_val, 32'hABCD);

        wb("wb_x0", 5'd0, 32'hDEAD);
        cycle("x0_same", 1'b1, 32'h00000433, 1'b1, 1'b0, 1'b1, 5'd0, 32'hBEEF);
        cycle("x0_read", 1'b1, 32'h00000433, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("x0.lit", ID_rs1_val, 32'd0);
        idle("drain1", 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom;
            cycle("rand", 1'($urandom_range(0, 1)), {r[31:7], ops[$urandom_range(0, 4)]},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end

        // Reset while a bundle is held stalled.
        cycle("pre_rst", 1'b1, 32'h40310233, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        idle("held", 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 32'h40310233, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("post_rst.rs1_lit", ID_rs1_val, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
